// File: rtl/multicycle_control_top.sv
// rtl/multicycle_control_top.sv - multicycle RV64I subset processor: control FSM plus datapath
//
// Purpose : top level of a 64-bit multicycle RISC-V core (add/sub/and/or/xor/slt,
//           their immediate forms, ld, sd, beq, bne, lui). Unknown encodings act as NOP.
// Ports   : clk   - system clock, all state changes on the rising edge
//           reset - synchronous active-high reset
// Modules : ram_sp (memories), instr_reg, processor (datapath), multicycle_control_top (FSM)

module ram_sp #(
   parameter int    WIDTH     = 32,
   parameter int    AW        = 8,
   parameter string init_file = ""
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata
);
   // Contents are not touched by reset; the image is placed into mem by the environment.
   logic [WIDTH-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end
endmodule

// Instruction register: holds the fetched instruction for the rest of its execution.
module instr_reg (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [31:0] din,
   output logic [31:0] instr_all,
   output logic [6:0]  opcode
);
   always_ff @(posedge clk) begin
      if (reset) begin
         instr_all <= '0;
      end else if (load) begin
         instr_all <= din;
      end
   end

   assign opcode = instr_all[6:0];
endmodule

// Datapath: PC/OLDPC, A, B, ALUOut, MDR, register file, ALU, immediates, both memories.
module processor (
   input  logic        clk,
   input  logic        reset,
   input  logic        ir_load,
   input  logic        pc_write,
   input  logic        pc_branch,
   input  logic        ab_load,
   input  logic        alu_src_imm,
   input  logic        imm_sel_s,
   input  logic [2:0]  alu_f3,
   input  logic        alu_sub,
   input  logic        aluout_load,
   input  logic        mdr_load,
   input  logic        rf_we,
   input  logic [1:0]  rf_src,
   input  logic        dmem_we,
   output logic [6:0]  opcode,
   output logic [2:0]  funct3,
   output logic [6:0]  funct7,
   output logic        a_eq_b
);
   logic [63:0] pc, oldpc, a, b, alu_out, mdr;
   logic [63:0] regs [32];
   logic [31:0] instr_all;
   logic [31:0] imem_data;
   logic [63:0] dmem_data;
   logic [63:0] imm_i, imm_s, imm_b, imm_u;
   logic [63:0] op2, alu_res, rf_wdata;
   logic [4:0]  rs1, rs2, rd;

   ram_sp #(.WIDTH(32), .AW(8), .init_file("")) memory_instr (
      .clk   (clk),
      .we    (1'b0),
      .addr  (pc[9:2]),
      .wdata (32'h0),
      .rdata (imem_data)
   );

   instr_reg instr_reg (
      .clk       (clk),
      .reset     (reset),
      .load      (ir_load),
      .din       (imem_data),
      .instr_all (instr_all),
      .opcode    (opcode)
   );

   // Doubleword addressed: the low three ALUOut bits are ignored.
   ram_sp #(.WIDTH(64), .AW(8), .init_file("")) memory_data (
      .clk   (clk),
      .we    (dmem_we),
      .addr  (alu_out[10:3]),
      .wdata (b),
      .rdata (dmem_data)
   );

   assign rd     = instr_all[11:7];
   assign funct3 = instr_all[14:12];
   assign rs1    = instr_all[19:15];
   assign rs2    = instr_all[24:20];
   assign funct7 = instr_all[31:25];

   assign imm_i = {{52{instr_all[31]}}, instr_all[31:20]};
   assign imm_s = {{52{instr_all[31]}}, instr_all[31:25], instr_all[11:7]};
   assign imm_b = {{51{instr_all[31]}}, instr_all[31], instr_all[7],
                   instr_all[30:25], instr_all[11:8], 1'b0};
   assign imm_u = {{32{instr_all[31]}}, instr_all[31:12], 12'h000};

   assign op2    = alu_src_imm ? (imm_sel_s ? imm_s : imm_i) : b;
   assign a_eq_b = (a == b);

   always_comb begin
      alu_res = a + op2;
      case (alu_f3)
         3'b000:  alu_res = alu_sub ? (a - op2) : (a + op2);
         3'b111:  alu_res = a & op2;
         3'b110:  alu_res = a | op2;
         3'b100:  alu_res = a ^ op2;
         3'b010:  alu_res = {63'h0, ($signed(a) < $signed(op2))};
         default: alu_res = a + op2;
      endcase
   end

   always_comb begin
      rf_wdata = alu_out;
      case (rf_src)
         2'd1:    rf_wdata = mdr;
         2'd2:    rf_wdata = imm_u;
         default: rf_wdata = alu_out;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc      <= '0;
         oldpc   <= '0;
         a       <= '0;
         b       <= '0;
         alu_out <= '0;
         mdr     <= '0;
         for (int i = 0; i < 32; i++) begin
            regs[i] <= '0;
         end
      end else begin
         // OLDPC keeps the address of the current instruction for branch targets.
         if (pc_write) begin
            oldpc <= pc;
            pc    <= pc + 64'd4;
         end else if (pc_branch) begin
            pc <= oldpc + imm_b;
         end
         if (ab_load) begin
            a <= regs[rs1];
            b <= regs[rs2];
         end
         if (aluout_load) begin
            alu_out <= alu_res;
         end
         if (mdr_load) begin
            mdr <= dmem_data;
         end
         // x0 is never written, so it always reads zero.
         if (rf_we && (rd != 5'd0)) begin
            regs[rd] <= rf_wdata;
         end
      end
   end
endmodule

module multicycle_control_top (
   input  logic clk,
   input  logic reset
);
   typedef enum logic [3:0] {
      FETCH       = 4'd0,
      FETCH_WAIT  = 4'd1,
      DECODE      = 4'd2,
      EXEC_R      = 4'd3,
      EXEC_I      = 4'd4,
      WB_ALU      = 4'd5,
      ADDR        = 4'd6,
      MEM_RD      = 4'd7,
      MEM_RD_WAIT = 4'd8,
      WB_MEM      = 4'd9,
      MEM_WR      = 4'd10,
      BRANCH      = 4'd11,
      LUI         = 4'd12,
      NOP         = 4'd13
   } state_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   state_t      state, next_state;
   logic        ir_load, pc_write, pc_branch, ab_load, alu_src_imm, imm_sel_s;
   logic [2:0]  alu_f3;
   logic        alu_sub, aluout_load, mdr_load, rf_we, dmem_we, dmem_we_req;
   logic [1:0]  rf_src;
   logic [6:0]  opcode, funct7;
   logic [2:0]  funct3;
   logic        a_eq_b, f3_alu_ok, r_ok;

   processor processor (
      .clk         (clk),
      .reset       (reset),
      .ir_load     (ir_load),
      .pc_write    (pc_write),
      .pc_branch   (pc_branch),
      .ab_load     (ab_load),
      .alu_src_imm (alu_src_imm),
      .imm_sel_s   (imm_sel_s),
      .alu_f3      (alu_f3),
      .alu_sub     (alu_sub),
      .aluout_load (aluout_load),
      .mdr_load    (mdr_load),
      .rf_we       (rf_we),
      .rf_src      (rf_src),
      .dmem_we     (dmem_we),
      .opcode      (opcode),
      .funct3      (funct3),
      .funct7      (funct7),
      .a_eq_b      (a_eq_b)
   );

   // The memory has no reset, so a store must not land on a reset edge.
   assign dmem_we = dmem_we_req & ~reset;

   assign f3_alu_ok = (funct3 == 3'b000) || (funct3 == 3'b111) || (funct3 == 3'b110) ||
                      (funct3 == 3'b100) || (funct3 == 3'b010);
   assign r_ok = ((funct7 == 7'b0000000) && f3_alu_ok) ||
                 ((funct7 == 7'b0100000) && (funct3 == 3'b000));

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= FETCH;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state  = FETCH;
      ir_load     = 1'b0;
      pc_write    = 1'b0;
      pc_branch   = 1'b0;
      ab_load     = 1'b0;
      alu_src_imm = 1'b0;
      imm_sel_s   = 1'b0;
      alu_f3      = 3'b000;
      alu_sub     = 1'b0;
      aluout_load = 1'b0;
      mdr_load    = 1'b0;
      rf_we       = 1'b0;
      rf_src      = 2'd0;
      dmem_we_req = 1'b0;
      case (state)
         FETCH: next_state = FETCH_WAIT;
         FETCH_WAIT: begin
            ir_load    = 1'b1;
            pc_write   = 1'b1;
            next_state = DECODE;
         end
         DECODE: begin
            ab_load = 1'b1;
            case (opcode)
               OP_R:      next_state = r_ok ? EXEC_R : NOP;
               OP_I:      next_state = f3_alu_ok ? EXEC_I : NOP;
               OP_LOAD:   next_state = (funct3 == 3'b011) ? ADDR : NOP;
               OP_STORE:  next_state = (funct3 == 3'b011) ? ADDR : NOP;
               OP_BRANCH: next_state = (funct3[2:1] == 2'b00) ? BRANCH : NOP;
               OP_LUI:    next_state = LUI;
               default:   next_state = NOP;
            endcase
         end
         EXEC_R: begin
            alu_f3      = funct3;
            alu_sub     = funct7[5];
            aluout_load = 1'b1;
            next_state  = WB_ALU;
         end
         EXEC_I: begin
            // Immediate bit 30 is data here, never a subtract select.
            alu_f3      = funct3;
            alu_src_imm = 1'b1;
            aluout_load = 1'b1;
            next_state  = WB_ALU;
         end
         WB_ALU: rf_we = 1'b1;
         ADDR: begin
            alu_src_imm = 1'b1;
            imm_sel_s   = (opcode == OP_STORE);
            aluout_load = 1'b1;
            next_state  = (opcode == OP_LOAD) ? MEM_RD : MEM_WR;
         end
         MEM_RD: next_state = MEM_RD_WAIT;
         MEM_RD_WAIT: begin
            mdr_load   = 1'b1;
            next_state = WB_MEM;
         end
         WB_MEM: begin
            rf_we  = 1'b1;
            rf_src = 2'd1;
         end
         MEM_WR: dmem_we_req = 1'b1;
         BRANCH: pc_branch = funct3[0] ? ~a_eq_b : a_eq_b;
         LUI: begin
            rf_we  = 1'b1;
            rf_src = 2'd2;
         end
         default: next_state = FETCH;
      endcase
   end
endmodule

// File: tb/tb_multicycle_control_top.sv
// tb/tb_multicycle_control_top.sv - directed self-checking bench for the multicycle core
module tb_multicycle_control_top;
   logic clk = 1'b0;
   logic reset = 1'b1;

   multicycle_control_top dut (
      .clk   (clk),
      .reset (reset)
   );

   always #5 clk = ~clk;

   typedef logic [7:0][31:0] prog_t;
   typedef struct {
      string       name;
      prog_t       prog;
      int          ncyc;
      int          rd;
      logic [63:0] exp;
   } vec_t;

   vec_t vecs[$];
   int total = 0;
   int passed = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
   endtask

   function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3,
                                         input int rd, input logic [6:0] op);
      logic [31:0] v;
      v = imm;
      return {v[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
   endfunction

   function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1,
                                         input int f3, input int rd);
      return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
   endfunction

   function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
      logic [31:0] v;
      v = imm;
      return {v[11:5], rs2[4:0], rs1[4:0], 3'b011, v[4:0], 7'b0100011};
   endfunction

   function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1,
                                         input int f3);
      logic [31:0] v;
      v = imm;
      return {v[12], v[10:5], rs2[4:0], rs1[4:0], f3[2:0], v[4:1], v[11], 7'b1100011};
   endfunction

   function automatic vec_t mk(input string name, input prog_t p, input int ncyc,
                               input int rd, input logic [63:0] exp);
      vec_t v;
      v.name = name; v.prog = p; v.ncyc = ncyc; v.rd = rd; v.exp = exp;
      return v;
   endfunction

   task automatic load(input prog_t p);
      for (int i = 0; i < 256; i++)
         dut.processor.memory_instr.mem[i] = (i < 8) ? p[i] : 32'h0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   localparam logic [6:0] OPI = 7'b0010011;

   initial begin
      prog_t p_add3, p_rtype, p_sltn, p_mem, p_beq, p_bne, p_loop, p_x0, p_lui, p_nop;
      p_add3 = '0; p_rtype = '0; p_sltn = '0; p_mem = '0; p_beq = '0;
      p_bne = '0; p_loop = '0; p_x0 = '0; p_lui = '0; p_nop = '0;

      p_add3[0] = enc_i(5, 0, 0, 1, OPI);
      p_add3[1] = enc_i(-3, 0, 0, 2, OPI);
      p_add3[2] = enc_r(0, 2, 1, 0, 3);

      p_rtype[0] = enc_i(32'hF0, 0, 0, 1, OPI);
      p_rtype[1] = enc_i(32'h3C, 0, 0, 2, OPI);
      p_rtype[2] = enc_r(7'h20, 2, 1, 0, 3);
      p_rtype[3] = enc_r(0, 2, 1, 7, 4);
      p_rtype[4] = enc_r(0, 2, 1, 6, 5);
      p_rtype[5] = enc_r(0, 2, 1, 4, 6);
      p_rtype[6] = enc_r(0, 2, 1, 2, 7);

      p_sltn[0] = enc_i(-1, 0, 0, 1, OPI);
      p_sltn[1] = enc_i(1, 0, 0, 2, OPI);
      p_sltn[2] = enc_r(0, 2, 1, 2, 3);

      p_mem[0] = enc_i(160, 0, 0, 1, OPI);
      p_mem[1] = enc_s(8, 1, 0);
      p_mem[2] = enc_i(8, 0, 3, 4, 7'b0000011);

      p_beq[0] = enc_b(8, 0, 0, 0);
      p_beq[1] = enc_i(9, 0, 0, 2, OPI);
      p_beq[2] = enc_i(4, 0, 0, 3, OPI);

      p_bne[0] = enc_b(8, 0, 0, 1);
      p_bne[1] = enc_i(9, 0, 0, 2, OPI);

      p_loop[0] = enc_i(3, 0, 0, 2, OPI);
      p_loop[1] = enc_i(1, 1, 0, 1, OPI);
      p_loop[2] = enc_b(-4, 2, 1, 1);

      p_x0[0]  = enc_i(7, 0, 0, 0, OPI);
      p_lui[0] = {20'h80000, 5'd5, 7'b0110111};
      p_nop[0] = 32'h0000007F;
      p_nop[1] = enc_i(1, 0, 0, 1, OPI);

      vecs.push_back(mk("addi_x1",   p_add3, 15, 1, 64'd5));
      vecs.push_back(mk("addi_neg",  p_add3, 15, 2, 64'hFFFF_FFFF_FFFF_FFFD));
      vecs.push_back(mk("add_x3",    p_add3, 15, 3, 64'd2));
      vecs.push_back(mk("sub",       p_rtype, 35, 3, 64'hB4));
      vecs.push_back(mk("and",       p_rtype, 35, 4, 64'h30));
      vecs.push_back(mk("or",        p_rtype, 35, 5, 64'hFC));
      vecs.push_back(mk("xor",       p_rtype, 35, 6, 64'hCC));
      vecs.push_back(mk("slt_pos",   p_rtype, 35, 7, 64'd0));
      vecs.push_back(mk("slt_neg",   p_sltn, 15, 3, 64'd1));
      vecs.push_back(mk("ld_after_sd", p_mem, 17, 4, 64'd160));
      vecs.push_back(mk("beq_skip",  p_beq, 9, 2, 64'd0));
      vecs.push_back(mk("beq_tgt",   p_beq, 9, 3, 64'd4));
      vecs.push_back(mk("bne_fall",  p_bne, 9, 2, 64'd9));
      vecs.push_back(mk("loop_x1",   p_loop, 40, 1, 64'd3));
      vecs.push_back(mk("x0_fixed",  p_x0, 5, 0, 64'd0));
      vecs.push_back(mk("lui",       p_lui, 4, 5, 64'hFFFF_FFFF_8000_0000));
      vecs.push_back(mk("nop_7f",    p_nop, 9, 1, 64'd1));

      // Reset state.
      load(p_add3);
      do_reset();
      check("rst_pc", dut.processor.pc, 64'd0);
      check("rst_ir", {32'h0, dut.processor.instr_all}, 64'd0);
      check("rst_state", 64'(int'(dut.state)), 64'd0);
      check("rst_x1", dut.processor.regs[1], 64'd0);

      for (int i = 0; i < vecs.size(); i++) begin
         load(vecs[i].prog);
         do_reset();
         cycles(vecs[i].ncyc);
         check(vecs[i].name, dut.processor.regs[vecs[i].rd], vecs[i].exp);
      end

      // Opcode sequence and PC after three 5-cycle instructions.
      load(p_add3);
      do_reset();
      cycles(2);
      check("opc0", {57'h0, dut.processor.opcode}, 64'h13);
      cycles(5);
      check("opc1", {57'h0, dut.processor.opcode}, 64'h13);
      cycles(5);
      check("opc2", {57'h0, dut.processor.opcode}, 64'h33);
      cycles(3);
      check("pc_15", dut.processor.pc, 64'd12);

      // ld latency of 7 cycles and data memory content.
      load(p_mem);
      do_reset();
      cycles(16);
      check("ld_cyc16", dut.processor.regs[4], 64'd0);
      cycles(1);
      check("ld_cyc17", dut.processor.regs[4], 64'd160);
      check("dmem_w1", dut.processor.memory_data.mem[1], 64'd160);

      // Not-taken branch leaves PC at old+4; NOP also advances by 4.
      load(p_bne);
      do_reset();
      cycles(4);
      check("bne_pc", dut.processor.pc, 64'd4);
      load(p_nop);
      do_reset();
      cycles(4);
      check("nop_pc", dut.processor.pc, 64'd4);
      check("nop_state", 64'(int'(dut.state)), 64'd0);

      // Reset during EXEC of add x3, then rerun.
      load(p_add3);
      do_reset();
      cycles(13);
      check("mid_state_exec", 64'(int'(dut.state)), 64'd3);
      reset = 1'b1;
      cycles(1);
      check("mid_rst_state", 64'(int'(dut.state)), 64'd0);
      check("mid_rst_pc", dut.processor.pc, 64'd0);
      check("mid_rst_x3", dut.processor.regs[3], 64'd0);
      check("mid_rst_aluout", dut.processor.alu_out, 64'd0);
      reset = 1'b0;
      cycles(15);
      check("rerun_x3", dut.processor.regs[3], 64'd2);
      check("rerun_pc", dut.processor.pc, 64'd12);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
